// File: rtl/multi_cycle_dp.sv
// Multi-cycle MIPS-subset core: one unified word memory and one ALU shared across cycles by a control FSM.
// Includes a program-load port, run/halt control, a sticky error flag, a retired counter and a register debug port.
module multi_cycle_dp #(
    parameter int          MEM_WORDS = 256,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         run,
    input  logic                         ld_we,
    input  logic [$clog2(MEM_WORDS)-1:0] ld_addr,
    input  logic [31:0]                  ld_data,
    input  logic [4:0]                   dbg_sel,
    output logic [31:0]                  dbg_data,
    output logic [31:0]                  pc,
    output logic [2:0]                   state,
    output logic                         halted,
    output logic                         err,
    output logic [CNT_W-1:0]             retired
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    state_t            state_q;
    logic [31:0]       pc_q;
    logic [31:0]       ir_q;
    logic [31:0]       a_q;
    logic [31:0]       b_q;
    logic [31:0]       target_q;
    logic [31:0]       alu_out_q;
    logic [31:0]       mdr_q;
    logic              halted_q;
    logic              err_q;
    logic [CNT_W-1:0]  retired_q;
    logic [31:0]       regs_q [32];
    logic [31:0]       mem_q  [MEM_WORDS];

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        wb_dest;
    logic [31:0]       imm_ext;
    logic [31:0]       wb_data;
    logic [31:0]       alu_d;
    logic              funct_ok;
    logic [AW-1:0]     fetch_idx;
    logic [AW-1:0]     data_idx;

    // The IR stays stable from ID through WB, so later stages decode straight from it.
    assign opcode    = ir_q[31:26];
    assign rs        = ir_q[25:21];
    assign rt        = ir_q[20:16];
    assign rd        = ir_q[15:11];
    assign funct     = ir_q[5:0];
    assign imm_ext   = {{16{ir_q[15]}}, ir_q[15:0]};
    assign wb_dest   = (opcode == OP_RTYPE) ? rd : rt;
    assign wb_data   = (opcode == OP_LW) ? mdr_q : alu_out_q;
    assign fetch_idx = pc_q[AW+1:2];
    assign data_idx  = alu_out_q[AW+1:2];

    always_comb begin
        alu_d    = a_q + imm_ext;
        funct_ok = 1'b1;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_ADD:  alu_d = a_q + b_q;
                FN_SUB:  alu_d = a_q - b_q;
                FN_AND:  alu_d = a_q & b_q;
                FN_OR:   alu_d = a_q | b_q;
                FN_SLT:  alu_d = {31'b0, ($signed(a_q) < $signed(b_q))};
                default: begin
                    alu_d    = 32'h0;
                    funct_ok = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= 32'h0;
            a_q       <= 32'h0;
            b_q       <= 32'h0;
            target_q  <= 32'h0;
            alu_out_q <= 32'h0;
            mdr_q     <= 32'h0;
            halted_q  <= 1'b0;
            err_q     <= 1'b0;
            retired_q <= '0;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_q <= S_IF;
                    end
                end
                S_IF: begin
                    ir_q    <= mem_q[fetch_idx];
                    pc_q    <= pc_q + 32'd4;
                    state_q <= S_ID;
                end
                S_ID: begin
                    a_q      <= regs_q[rs];
                    b_q      <= regs_q[rt];
                    target_q <= pc_q + (imm_ext << 2);
                    case (opcode)
                        OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ: begin
                            state_q <= S_EX;
                        end
                        OP_J: begin
                            pc_q      <= {pc_q[31:28], ir_q[25:0], 2'b00};
                            retired_q <= retired_q + CNT_ONE;
                            state_q   <= S_IF;
                        end
                        OP_HALT: begin
                            retired_q <= retired_q + CNT_ONE;
                            halted_q  <= 1'b1;
                            state_q   <= S_HALT;
                        end
                        default: begin
                            err_q    <= 1'b1;
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end
                    endcase
                end
                S_EX: begin
                    alu_out_q <= alu_d;
                    if (opcode == OP_BEQ) begin
                        if (a_q == b_q) begin
                            pc_q <= target_q;
                        end
                        retired_q <= retired_q + CNT_ONE;
                        state_q   <= S_IF;
                    end else if (!funct_ok) begin
                        err_q    <= 1'b1;
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else if (opcode == OP_LW || opcode == OP_SW) begin
                        state_q <= S_MEM;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (opcode == OP_SW) begin
                        retired_q <= retired_q + CNT_ONE;
                        state_q   <= S_IF;
                    end else begin
                        mdr_q   <= mem_q[data_idx];
                        state_q <= S_WB;
                    end
                end
                S_WB: begin
                    if (wb_dest != 5'd0) begin
                        regs_q[wb_dest] <= wb_data;
                    end
                    retired_q <= retired_q + CNT_ONE;
                    state_q   <= S_IF;
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Memory is deliberately left out of reset; only the FSM state gates its two write sources.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && ld_we) begin
            mem_q[ld_addr] <= ld_data;
        end else if (state_q == S_MEM && opcode == OP_SW) begin
            mem_q[data_idx] <= b_q;
        end
    end

    assign dbg_data = (dbg_sel == 5'd0) ? 32'h0 : regs_q[dbg_sel];
    assign pc       = pc_q;
    assign state    = state_q;
    assign halted   = halted_q;
    assign err      = err_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_multi_cycle_dp.sv
// Directed and randomized programs for multi_cycle_dp, compared against an instruction-level
// interpreter that tracks architectural registers, memory, pc, retired count and cycle cost.
module tb_multi_cycle_dp;
    localparam int MW = 256;
    localparam int AW = $clog2(MW);
    localparam int CW = 16;
    localparam logic [31:0] HALT_W = 32'hFC00_0000;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            run;
    logic            ld_we;
    logic [AW-1:0]   ld_addr;
    logic [31:0]     ld_data;
    logic [4:0]      dbg_sel;
    logic [31:0]     dbg_data;
    logic [31:0]     pc;
    logic [2:0]      state;
    logic            halted;
    logic            err;
    logic [CW-1:0]   retired;

    int checks = 0;
    int errors = 0;

    logic [31:0]     mMem [MW];
    logic [31:0]     mRegs [32];
    logic [31:0]     mPc;
    logic [CW-1:0]   mRetired;
    logic            mErr;
    int              mCycles;
    logic [31:0]     prog [$];
    logic [5:0]      fnTable [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    always #5 clk = ~clk;

    multi_cycle_dp #(.MEM_WORDS(MW), .RESET_PC(32'h0), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_data(ld_data), .dbg_sel(dbg_sel), .dbg_data(dbg_data), .pc(pc),
        .state(state), .halted(halted), .err(err), .retired(retired)
    );

    function automatic logic [31:0] encR(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] encI(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] encJ(logic [25:0] tgt);
        return {6'h02, tgt};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int r = 0; r < 32; r++) mRegs[r] = 32'h0;
        mPc      = 32'h0;
        mRetired = '0;
        mErr     = 1'b0;
        mCycles  = 0;
    endtask

    // Executes whole instructions; each one adds its architectural cycle cost to mCycles.
    task automatic modelRun();
        logic [31:0] w, a, b, imm, r, addr;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        bit          done, ok;
        done = 0;
        for (int n = 0; n < 1000 && !done; n++) begin
            w    = mMem[(mPc / 4) % MW];
            mPc  = mPc + 4;
            op   = w[31:26];
            rs   = w[25:21];
            rt   = w[20:16];
            rd   = w[15:11];
            imm  = {{16{w[15]}}, w[15:0]};
            a    = mRegs[rs];
            b    = mRegs[rt];
            addr = a + imm;
            case (op)
                6'h00: begin
                    ok = 1;
                    r  = 32'h0;
                    case (w[5:0])
                        6'h20:   r = a + b;
                        6'h22:   r = a - b;
                        6'h24:   r = a & b;
                        6'h25:   r = a | b;
                        6'h2A:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        default: ok = 0;
                    endcase
                    if (ok) begin
                        mRegs[rd] = r; mCycles += 4; mRetired++;
                    end else begin
                        mErr = 1; mCycles += 3; done = 1;
                    end
                end
                6'h08: begin mRegs[rt] = addr; mCycles += 4; mRetired++; end
                6'h23: begin mRegs[rt] = mMem[(addr / 4) % MW]; mCycles += 5; mRetired++; end
                6'h2B: begin mMem[(addr / 4) % MW] = b; mCycles += 4; mRetired++; end
                6'h04: begin
                    if (a == b) mPc = mPc + imm * 4;
                    mCycles += 3; mRetired++;
                end
                6'h02: begin
                    mPc = (mPc & 32'hF000_0000) | ({6'b0, w[25:0]} * 4);
                    mCycles += 2; mRetired++;
                end
                6'h3F: begin mCycles += 2; mRetired++; done = 1; end
                default: begin mErr = 1; mCycles += 2; done = 1; end
            endcase
            mRegs[0] = 32'h0;
        end
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic loadWord(input int addr, input logic [31:0] data);
        ld_we   = 1'b1;
        ld_addr = addr[AW-1:0];
        ld_data = data;
        @(negedge clk);
        ld_we   = 1'b0;
        mMem[addr % MW] = data;
    endtask

    task automatic readReg(input int r, output logic [31:0] v);
        dbg_sel = r[4:0];
        @(negedge clk);
        v = dbg_data;
    endtask

    // Reset, load prog from word 0, predict with the model, then run the core until it halts.
    task automatic applyStimulus(input int budget, output int cyc);
        resetDut();
        modelReset();
        foreach (prog[i]) loadWord(i, prog[i]);
        modelRun();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        cyc = 1;
        while (halted !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic checkProgram(input string name, input int cyc);
        logic [31:0] v;
        checkOutput({name, "_halted"}, 32'(halted), 32'd1);
        checkOutput({name, "_err"}, 32'(err), 32'(mErr));
        checkOutput({name, "_pc"}, pc, mPc);
        checkOutput({name, "_retired"}, 32'(retired), 32'(mRetired));
        checkOutput({name, "_cycles"}, 32'(cyc), 32'(mCycles + 1));
        for (int r = 0; r < 32; r++) begin
            readReg(r, v);
            checkOutput($sformatf("%s_reg%0d", name, r), v, mRegs[r]);
        end
    endtask

    initial begin
        int          cyc;
        int          n, k;
        logic [31:0] v;
        logic [4:0]  rs, rt, rd;
        logic [15:0] off;

        rst_n = 1'b0; run = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = 32'h0; dbg_sel = 5'd5;
        #12;
        checkOutput("rst_pc", pc, 32'h0);
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_retired", 32'(retired), 32'd0);
        checkOutput("rst_reg5", dbg_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        prog = '{32'h2001_0005, HALT_W};
        applyStimulus(50, cyc);
        checkProgram("load", cyc);
        readReg(1, v);
        checkOutput("load_reg1_const", v, 32'd5);
        checkOutput("load_retired_const", 32'(retired), 32'd2);
        checkOutput("load_pc_const", pc, 32'd8);
        checkOutput("load_cycles_const", 32'(cyc), 32'd7);

        prog = '{encI(6'h08, 0, 1, 16'd5), encI(6'h08, 0, 2, 16'd7),
                 encR(1, 2, 3, 6'h20), encR(1, 2, 4, 6'h22), encR(1, 2, 5, 6'h24),
                 encR(1, 2, 6, 6'h25), encR(1, 2, 7, 6'h2A), HALT_W};
        applyStimulus(100, cyc);
        checkProgram("alu", cyc);
        readReg(3, v); checkOutput("alu_add", v, 32'd12);
        readReg(4, v); checkOutput("alu_sub", v, 32'hFFFF_FFFE);
        readReg(5, v); checkOutput("alu_and", v, 32'd5);
        readReg(6, v); checkOutput("alu_or", v, 32'd7);
        readReg(7, v); checkOutput("alu_slt", v, 32'd1);
        checkOutput("alu_cycles_const", 32'(cyc), 32'd31);

        prog = '{encI(6'h08, 0, 1, 16'd5), encI(6'h2B, 0, 1, 16'h0040),
                 encI(6'h23, 0, 8, 16'h0040), encI(6'h23, 0, 9, 16'(MW * 4 + 64)), HALT_W};
        applyStimulus(100, cyc);
        checkProgram("mem", cyc);
        readReg(8, v); checkOutput("mem_lw", v, 32'd5);
        readReg(9, v); checkOutput("mem_alias", v, 32'd5);
        checkOutput("mem_cycles_const", 32'(cyc), 32'd21);

        // Taken beq back to itself loops every 3 cycles until reset aborts it.
        resetDut();
        loadWord(0, encI(6'h04, 1, 1, 16'hFFFF));
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        repeat (15) @(negedge clk);
        checkOutput("beq_loop_state", 32'(state), 32'd1);
        checkOutput("beq_loop_pc", pc, 32'h0);
        checkOutput("beq_loop_retired", 32'(retired), 32'd5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_pc", pc, 32'h0);
        checkOutput("abort_retired", 32'(retired), 32'd0);
        checkOutput("abort_state", 32'(state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        prog = '{encI(6'h08, 0, 1, 16'd5), encI(6'h04, 1, 0, 16'd3), encJ(26'h10)};
        for (int i = 3; i < 16; i++) prog.push_back(32'h0);
        prog.push_back(HALT_W);
        applyStimulus(100, cyc);
        checkProgram("jump", cyc);
        checkOutput("jump_pc_const", pc, 32'h44);
        checkOutput("jump_cycles_const", 32'(cyc), 32'd12);

        prog = '{encI(6'h08, 0, 1, 16'd5), 32'hF800_0000};
        applyStimulus(50, cyc);
        checkProgram("badop", cyc);
        checkOutput("badop_err_const", 32'(err), 32'd1);
        checkOutput("badop_retired_const", 32'(retired), 32'd1);

        prog = '{encI(6'h08, 0, 1, 16'd5), encR(1, 1, 3, 6'h00)};
        applyStimulus(50, cyc);
        checkProgram("badfn", cyc);
        checkOutput("badfn_err_const", 32'(err), 32'd1);

        prog = '{encI(6'h08, 0, 1, 16'd5), encR(1, 1, 0, 6'h20), HALT_W};
        applyStimulus(50, cyc);
        checkProgram("zero", cyc);
        readReg(0, v);
        checkOutput("zero_reg0_const", v, 32'h0);

        // A load-port write of a halt over a running self-loop must not take effect.
        resetDut();
        loadWord(0, encI(6'h04, 0, 0, 16'hFFFF));
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        ld_we = 1'b1; ld_addr = '0; ld_data = HALT_W;
        repeat (3) @(negedge clk);
        ld_we = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("ldwe_running_halted", 32'(halted), 32'd0);

        for (int t = 0; t < 20; t++) begin
            resetDut();
            for (int d = 128; d < 144; d++) loadWord(d, $urandom);
            prog.delete();
            n = $urandom_range(6, 12);
            for (int i = 0; i < n; i++) begin
                k  = $urandom_range(0, 9);
                rs = 5'($urandom_range(0, 7));
                rt = 5'($urandom_range(0, 7));
                rd = 5'($urandom_range(0, 7));
                off = 16'(32'h200 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3)
                          + (($urandom_range(0, 1) == 1) ? MW * 4 : 0));
                if (k < 3)       prog.push_back(encI(6'h08, rs, rt, 16'($urandom)));
                else if (k < 7)  prog.push_back(encR(rs, rt, rd, fnTable[$urandom_range(0, 4)]));
                else if (k == 7) prog.push_back(encI(6'h23, 0, rt, off));
                else if (k == 8) prog.push_back(encI(6'h2B, 0, rt, off));
                else             prog.push_back(encI(6'h04, rs, rt, (i < n - 1) ? 16'd1 : 16'd0));
            end
            prog.push_back(HALT_W);
            applyStimulus(300, cyc);
            checkProgram($sformatf("rand%0d", t), cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
